// File: rtl/booth_mult_unit.sv
// Sequential radix-2 Booth multiplier for the HI/LO write path: 33 steps, 34-cycle latency.
// Optional macro MULTU_EN adds the unsigned_op port for multu (zero-extended operands).
module booth_mult_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
`ifdef MULTU_EN
    input  logic        unsigned_op,
`endif
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Count value seen during the final (33rd) step
    localparam logic [CW-1:0] LAST_STEP = CW'(32);

    logic [1:0]    state;
    logic [W:0]    m;
    logic [W+1:0]  acc;
    logic [W:0]    q;
    logic          q_m1;
    logic [CW-1:0] count;

    logic [1:0]    state_next;
    logic [W+1:0]  m_sext;
    logic [W+1:0]  acc_sum;
    logic [W+1:0]  step_acc;
    logic [W:0]    step_q;
    logic          step_q_m1;
    logic [63:0]   product;
    logic          accept;
    logic          finish;
    logic          ext_a;
    logic          ext_b;

    // Next state, one Booth step, and operand extension
    always_comb begin
        state_next = state;
        m_sext     = {m[W], m};
        acc_sum    = acc;
        accept     = 1'b0;
        finish     = 1'b0;
`ifdef MULTU_EN
        ext_a      = unsigned_op ? 1'b0 : a[W-1];
        ext_b      = unsigned_op ? 1'b0 : b[W-1];
`else
        ext_a      = a[W-1];
        ext_b      = b[W-1];
`endif

        case ({q[0], q_m1})
            2'b01:   acc_sum = acc + m_sext;
            2'b10:   acc_sum = acc - m_sext;
            default: acc_sum = acc;
        endcase

        step_acc  = {acc_sum[W+1], acc_sum[W+1:1]};
        step_q    = {acc_sum[0], q[W:1]};
        step_q_m1 = q[0];
        product   = {step_acc[W-2:0], step_q};

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                    accept     = 1'b1;
                end
            end
            ST_RUN: begin
                if (count == LAST_STEP) begin
                    state_next = ST_DONE;
                    finish     = 1'b1;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_next = ST_RUN;
                    accept     = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            m     <= '0;
            acc   <= '0;
            q     <= '0;
            q_m1  <= 1'b0;
            count <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next == ST_RUN);
            done  <= (state_next == ST_DONE);
            if (accept) begin
                m     <= {ext_a, a};
                q     <= {ext_b, b};
                acc   <= '0;
                q_m1  <= 1'b0;
                count <= '0;
            end else if (state == ST_RUN) begin
                acc   <= step_acc;
                q     <= step_q;
                q_m1  <= step_q_m1;
                count <= count + CW'(1);
            end
            // Results only move on a completed run, so aborted/new runs leave them intact
            if (finish) begin
                hi <= product[63:32];
                lo <= product[31:0];
            end
        end
    end

endmodule

// File: tb/tb_booth_mult_unit.sv
// Directed, table-driven bench for booth_mult_unit; works with or without MULTU_EN.
module tb_booth_mult_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        unsigned_op;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    booth_mult_unit dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .a           (a),
        .b           (b),
`ifdef MULTU_EN
        .unsigned_op (unsigned_op),
`endif
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        u;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[12];
    int   nvec;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Launch one operation from the current negedge; returns at the negedge of the done cycle
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tu,
                          input int inject_cyc, input logic chk_hold, input logic [31:0] hold_lo,
                          output int done_cyc, output int busy_cnt, output int busy_bad,
                          output int hold_bad);
        a = ta;
        b = tb_v;
        unsigned_op = tu;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        done_cyc = -1;
        busy_cnt = 0;
        busy_bad = 0;
        hold_bad = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            start = 1'b0;
            if (busy) begin
                busy_cnt++;
                if (k > 33) busy_bad++;
            end else if (k <= 33) begin
                busy_bad++;
            end
            if (done) begin
                done_cyc = k;
                break;
            end
            if (chk_hold && lo !== hold_lo) hold_bad++;
            if (k == inject_cyc) begin
                a = 32'd9;
                b = 32'd9;
                start = 1'b1;
            end
        end
    endtask

    int dc, bc, bb, hb, dcount;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        unsigned_op = 1'b0;

        nvec = 0;
        vecs[nvec++] = '{32'd3,        32'd4,        1'b0, 32'h0000_0000, 32'h0000_000C};
        vecs[nvec++] = '{32'hFFFF_FFFF, 32'd1,        1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[nvec++] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0000_0000};
        vecs[nvec++] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 32'h3FFF_FFFF, 32'h0000_0001};
        vecs[nvec++] = '{32'hFFFF_FFFE, 32'd5,        1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF6};
        vecs[nvec++] = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 1'b0, 32'h0000_0000, 32'h0000_0015};
        vecs[nvec++] = '{32'h1234_5678, 32'h10,       1'b0, 32'h0000_0001, 32'h2345_6780};
        vecs[nvec++] = '{32'h0,        32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 32'h0000_0000};
        vecs[nvec++] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h0000_0001};
`ifdef MULTU_EN
        vecs[nvec++] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[nvec++] = '{32'h8000_0000, 32'd2,        1'b1, 32'h0000_0001, 32'h0000_0000};
        vecs[nvec++] = '{32'h8000_0000, 32'd2,        1'b0, 32'hFFFF_FFFF, 32'h0000_0000};
`endif

        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);

        for (int i = 0; i < nvec; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].u, 0, 1'b0, 32'd0, dc, bc, bb, hb);
            check($sformatf("vec%0d_done_cycle", i), 64'(dc), 64'd34);
            check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'd33);
            check($sformatf("vec%0d_busy_window", i), 64'(bb), 64'd0);
            check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
            check($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
            @(negedge clock);
            check($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
        end

        // Reset mid-run discards the run and clears results
        run_op(32'd3, 32'd4, 1'b0, 0, 1'b0, 32'd0, dc, bc, bb, hb);
        check("pre_abort_lo", 64'(lo), 64'hC);
        @(negedge clock);
        a = 32'd5;
        b = 32'd6;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        dcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (done || busy) dcount++;
        end
        check("abort_no_done", 64'(dcount), 64'd0);
        run_op(32'd7, 32'd7, 1'b0, 0, 1'b0, 32'd0, dc, bc, bb, hb);
        check("fresh_done_cycle", 64'(dc), 64'd34);
        check("fresh_hilo", {hi, lo}, 64'h31);
        @(negedge clock);

        // Reset and start together: start is dropped
        reset = 1'b1;
        start = 1'b1;
        a = 32'd2;
        b = 32'd2;
        @(posedge clock);
        #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clock);
        check("rst_start_busy", 64'(busy), 64'd0);
        @(negedge clock);
        check("rst_start_busy2", 64'(busy), 64'd0);

        // Start during RUN is ignored
        run_op(32'd2, 32'd3, 1'b0, 5, 1'b0, 32'd0, dc, bc, bb, hb);
        check("ignore_done_cycle", 64'(dc), 64'd34);
        check("ignore_lo", {hi, lo}, 64'd6);
        @(negedge clock);
        check("ignore_no_rerun", 64'(busy), 64'd0);
        @(negedge clock);

        // Back-to-back: second start in the DONE cycle
        run_op(32'd2, 32'd3, 1'b0, 0, 1'b0, 32'd0, dc, bc, bb, hb);
        check("b2b_first_cycle", 64'(dc), 64'd34);
        check("b2b_first_lo", {hi, lo}, 64'd6);
        run_op(32'hFFFF_FFFE, 32'd5, 1'b0, 0, 1'b1, 32'd6, dc, bc, bb, hb);
        check("b2b_second_cycle", 64'(34 + dc), 64'd68);
        check("b2b_busy_window", 64'(bb), 64'd0);
        check("b2b_hold", 64'(hb), 64'd0);
        check("b2b_second_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
